// File: rtl/xor_gate_pkg.sv
// Shared constants and types for the xor_gate block.
// The capture-statistics counter (macro XOR_GATE_STATS_EN) uses these types.
package xor_gate_pkg;

    localparam int STAT_W = 16;

    typedef logic [STAT_W-1:0] stat_cnt_t;

    localparam stat_cnt_t STAT_MAX = '1;

    // Saturating increment: stays at all-ones instead of wrapping to zero.
    function automatic stat_cnt_t stat_sat_inc(input stat_cnt_t cnt);
        return (cnt == STAT_MAX) ? cnt : cnt + stat_cnt_t'(1);
    endfunction

endpackage

// File: rtl/xor_popcount.sv
// Combinational population count of a WIDTH-bit word; the result is
// sized to hold 0..WIDTH without wrapping.
module xor_popcount #(
    parameter int WIDTH = 1,
    parameter int HD_W  = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] d,
    output logic [HD_W-1:0]  cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + HD_W'(d[i]);
        end
    end

endmodule

// File: rtl/xor_gate.sv
// Bitwise XOR with a combinational output plus registered XOR, Hamming distance
// and parity. Optional capture counter enabled by macro XOR_GATE_STATS_EN.
module xor_gate
    import xor_gate_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int HD_W  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
`ifdef XOR_GATE_STATS_EN
    input  logic             stat_clr,
    output stat_cnt_t        stat_cnt,
`endif
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid,
    output logic [HD_W-1:0]  hd,
    output logic             parity
);

    logic [WIDTH-1:0] y_reg;
    logic [HD_W-1:0]  hd_reg;
    logic [HD_W-1:0]  hd_next;
    logic             parity_reg;
    logic             out_valid_reg;

    assign y = a ^ b;

    xor_popcount #(
        .WIDTH (WIDTH),
        .HD_W  (HD_W)
    ) u_popcount (
        .d   (y),
        .cnt (hd_next)
    );

    // Results hold while idle; only out_valid drops when nothing is captured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_reg         <= '0;
            hd_reg        <= '0;
            parity_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                y_reg      <= y;
                hd_reg     <= hd_next;
                parity_reg <= ^y;
            end
        end
    end

    assign y_q       = y_reg;
    assign hd        = hd_reg;
    assign parity    = parity_reg;
    assign out_valid = out_valid_reg;

`ifdef XOR_GATE_STATS_EN
    stat_cnt_t stat_cnt_reg;

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            stat_cnt_reg <= '0;
        end else if (in_valid && (a != b)) begin
            stat_cnt_reg <= stat_sat_inc(stat_cnt_reg);
        end
    end

    assign stat_cnt = stat_cnt_reg;
`endif

endmodule

// File: tb/tb_xor_gate.sv
// Self-checking bench for xor_gate: WIDTH=1 and WIDTH=8 instances driven with
// directed and random stimulus against a behavioural model.
module tb_xor_gate;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a1, b1, iv1;
    logic [7:0] a8, b8;
    logic       iv8;
    logic       y1, yq1, ov1, hd1, par1;
    logic [7:0] y8, yq8;
    logic       ov8, par8;
    logic [3:0] hd8;
`ifdef XOR_GATE_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_cnt1, stat_cnt8;
    int unsigned m_cnt8;
`endif

    int tests = 0;
    int fails = 0;

    // model state
    logic [7:0] m_yq8;
    int         m_hd8;
    logic       m_ov8;
    logic       m_yq1, m_ov1;

    always #5 clk = ~clk;

    xor_gate #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(iv1),
`ifdef XOR_GATE_STATS_EN
        .stat_clr(stat_clr), .stat_cnt(stat_cnt1),
`endif
        .y(y1), .y_q(yq1), .out_valid(ov1), .hd(hd1), .parity(par1)
    );

    xor_gate #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(iv8),
`ifdef XOR_GATE_STATS_EN
        .stat_clr(stat_clr), .stat_cnt(stat_cnt8),
`endif
        .y(y8), .y_q(yq8), .out_valid(ov8), .hd(hd8), .parity(par8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_regs();
        check("y_q8", 64'(yq8), 64'(m_yq8));
        check("hd8", 64'(hd8), 64'(m_hd8));
        check("parity8", 64'(par8), 64'(m_hd8 % 2));
        check("out_valid8", 64'(ov8), 64'(m_ov8));
        check("y_q1", 64'(yq1), 64'(m_yq1));
        check("hd1", 64'(hd1), 64'(m_yq1));
        check("parity1", 64'(par1), 64'(m_yq1));
        check("out_valid1", 64'(ov1), 64'(m_ov1));
`ifdef XOR_GATE_STATS_EN
        check("stat_cnt8", 64'(stat_cnt8), 64'(m_cnt8));
`endif
    endtask

    // One clock: apply inputs, check y combinationally, clock, update model, check.
    task automatic step(input logic [7:0] ta8, input logic [7:0] tb8, input logic v8,
                        input logic ta1, input logic tb1, input logic v1, input logic r);
        a8 = ta8; b8 = tb8; iv8 = v8;
        a1 = ta1; b1 = tb1; iv1 = v1;
        rst_n = r;
        #1;
        check("y8", 64'(y8), 64'(ta8 ^ tb8));
        check("y1", 64'(y1), 64'(ta1 ^ tb1));
        @(posedge clk);
        #1;
        if (!r) begin
            m_yq8 = '0; m_hd8 = 0; m_ov8 = 1'b0;
            m_yq1 = 1'b0; m_ov1 = 1'b0;
`ifdef XOR_GATE_STATS_EN
            m_cnt8 = 0;
`endif
        end else begin
            m_ov8 = v8;
            m_ov1 = v1;
            if (v8) begin
                m_yq8 = ta8 ^ tb8;
                m_hd8 = $countones(ta8 ^ tb8);
            end
            if (v1) m_yq1 = ta1 ^ tb1;
`ifdef XOR_GATE_STATS_EN
            if (v8 && ta8 != tb8 && m_cnt8 < 65535) m_cnt8++;
`endif
        end
        $display("[TB] a8=%02h b8=%02h v8=%0d a1=%0d b1=%0d v1=%0d rst_n=%0d -> y_q8=%02h hd8=%0d ov8=%0d",
                 ta8, tb8, v8, ta1, tb1, v1, r, yq8, hd8, ov8);
        check_regs();
    endtask

    initial begin
        a8 = '0; b8 = '0; iv8 = 1'b0;
        a1 = 1'b0; b1 = 1'b0; iv1 = 1'b0;
        rst_n = 1'b0;
`ifdef XOR_GATE_STATS_EN
        stat_clr = 1'b0;
        m_cnt8 = 0;
`endif
        m_yq8 = '0; m_hd8 = 0; m_ov8 = 1'b0; m_yq1 = 1'b0; m_ov1 = 1'b0;
        #6;

        // reset state, with in_valid high to show reset priority
        step(8'h12, 8'h34, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // WIDTH=1 truth table, each pair held 10 time units
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            a1 = ab[1]; b1 = ab[0];
            #10;
            check("truth_y1", 64'(y1), 64'(ab[1] != ab[0]));
            $display("[TB] truth a=%0d b=%0d y=%0d", ab[1], ab[0], y1);
        end

        // all bits differ, then a capture followed by three idle edges
        step(8'hFF, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(8'hA5, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(8'h3C, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("hold_yq", 64'(yq8), 64'h0000_0000_0000_00AA);
        check("hold_hd", 64'(hd8), 64'd4);

        // equal operands: zero distance
        step(8'h5A, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // reset while in_valid is high; y must keep tracking
        step(8'hF0, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        // deasserted reset with idle input: no out_valid pulse
        step(8'h11, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(8'h11, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // randomized back-to-back traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            step(8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 19) != 0));
        end

`ifdef XOR_GATE_STATS_EN
        // saturation of the capture counter, then clear
        a8 = 8'h01; b8 = 8'h00; iv8 = 1'b1; rst_n = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        check("stat_sat", 64'(stat_cnt8), 64'hFFFF);
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        check("stat_clr", 64'(stat_cnt8), 64'h0);
        stat_clr = 1'b0;
        $display("[TB] stats saturate/clear done");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
